// File: rtl/adder_accum_if.sv
// adder_accum_if: one valid/ready stream of W-bit data, used for both the sample input and the block-total output.
interface adder_accum_if #(
    parameter int W = 2
);
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    modport master(output valid, output data, input ready);
    modport slave(input valid, input data, output ready);
endinterface

// File: rtl/adder_accum.sv
// adder_accum: sums fixed blocks of N 2-bit samples and presents each total on an output handshake until it is taken.
module adder_accum #(
    parameter int N     = 8,
    parameter int ACC_W = 5,
    parameter int CNT_W = 3
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic                clr,
    adder_accum_if.slave        in_s,
    adder_accum_if.master       out_m,
    output logic [7:0]          blk_cnt
);
    typedef enum logic {ACC, HOLD} state_t;
    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_blk_cnt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_accept;
    logic               w_last;
    // Handshake flags come straight from the state register, so no input reaches an output combinationally.
    assign in_s.ready  = r_state == ACC;
    assign out_m.valid = r_state == HOLD;
    assign out_m.data  = r_out_data;
    assign blk_cnt     = r_blk_cnt;
    assign w_sum       = r_acc + ACC_W'(in_s.data);
    assign w_accept    = in_s.valid && r_state == ACC;
    assign w_last      = r_cnt == CNT_W'(N - 1);
    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_blk_cnt  <= '0;
        end else if (clr) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else if (r_state == ACC) begin
            if (w_accept) begin
                r_acc <= w_last ? '0 : w_sum;
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_out_data <= w_sum;
                    r_state    <= HOLD;
                end
            end
        end else if (out_m.ready) begin
            r_state   <= ACC;
            r_blk_cnt <= r_blk_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: directed vectors against hand-computed block totals for the default build and an N=2 build.
module tb_adder_accum;
    logic m_clock = 1'b0;
    logic p_reset = 1'b0;
    logic clr = 1'b0;
    logic [7:0] blk_cnt, blk_cnt2;
    int n_chk = 0;
    int n_pass = 0;
    adder_accum_if #(.W(2)) in_if();
    adder_accum_if #(.W(5)) out_if();
    adder_accum_if #(.W(2)) in2_if();
    adder_accum_if #(.W(3)) out2_if();
    always #5 m_clock = ~m_clock;
    adder_accum #(.N(8), .ACC_W(5), .CNT_W(3)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .clr(clr),
        .in_s(in_if), .out_m(out_if), .blk_cnt(blk_cnt)
    );
    adder_accum #(.N(2), .ACC_W(3), .CNT_W(1)) dut2 (
        .m_clock(m_clock), .p_reset(p_reset), .clr(clr),
        .in_s(in2_if), .out_m(out2_if), .blk_cnt(blk_cnt2)
    );
    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic feed(input int cnt, input logic [1:0] d);
        in_if.valid = 1'b1;
        in_if.data  = d;
        for (int i = 0; i < cnt; i++) tick();
        in_if.valid = 1'b0;
    endtask
    initial begin
        in_if.valid = 0; in_if.data = 0; out_if.ready = 0;
        in2_if.valid = 0; in2_if.data = 0; out2_if.ready = 0;
        tick(); tick();
        p_reset = 1'b1;
        check("rst_in_ready", in_if.ready, 1);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        // full block of 3s with the N=2 build running alongside
        in_if.valid = 1; in_if.data = 3;
        in2_if.valid = 1; in2_if.data = 3;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) begin
                in2_if.valid = 0;
                check("n2_out_valid", out2_if.valid, 1);
                check("n2_out_data", out2_if.data, 6);
                check("n2_in_ready", in2_if.ready, 0);
            end
            if (i == 6) check("b1_not_yet", out_if.valid, 0);
        end
        check("b1_out_valid", out_if.valid, 1);
        check("b1_out_data", out_if.data, 24);
        check("b1_in_ready", in_if.ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", out_if.data, 24);
            check("stall_valid", out_if.valid, 1);
        end
        in_if.valid = 0; out_if.ready = 1;
        tick();
        out_if.ready = 0;
        check("b1_taken_valid", out_if.valid, 0);
        check("b1_blk_cnt", blk_cnt, 1);
        check("b1_in_ready", in_if.ready, 1);
        // streaming 0,1,2,3 with out_ready high: 9-cycle period
        out_if.ready = 1; in_if.valid = 1;
        for (int b = 0; b < 3; b++) begin
            check("st_ready_start", in_if.ready, 1);
            for (int j = 0; j < 8; j++) begin
                in_if.data = 2'(j % 4);
                tick();
            end
            in_if.data = 0;
            check("st_out_valid", out_if.valid, 1);
            check("st_out_data", out_if.data, 12);
            check("st_gap", in_if.ready, 0);
            tick();
            check("st_taken", out_if.valid, 0);
        end
        check("st_blk_cnt", blk_cnt, 4);
        in_if.valid = 0; out_if.ready = 0;
        // sparse valid: idle cycles carry junk data that must not count
        for (int j = 0; j < 8; j++) begin
            in_if.valid = 1; in_if.data = 1;
            tick();
            if (j == 7) break;
            in_if.valid = 0; in_if.data = 3;
            tick(); tick();
        end
        in_if.valid = 0;
        check("sp_out_valid", out_if.valid, 1);
        check("sp_out_data", out_if.data, 8);
        out_if.ready = 1;
        tick();
        out_if.ready = 0;
        check("sp_blk_cnt", blk_cnt, 5);
        // clr mid-block, with a sample presented in the clr cycle
        feed(5, 2);
        clr = 1; in_if.valid = 1; in_if.data = 2;
        tick();
        clr = 0; in_if.valid = 0;
        check("clr_in_ready", in_if.ready, 1);
        check("clr_out_valid", out_if.valid, 0);
        feed(7, 1);
        check("clr_partial", out_if.valid, 0);
        feed(1, 1);
        check("clr_out_valid2", out_if.valid, 1);
        check("clr_out_data", out_if.data, 8);
        clr = 1; out_if.ready = 1;
        tick();
        clr = 0; out_if.ready = 0;
        check("clr_hold_valid", out_if.valid, 0);
        check("clr_hold_data", out_if.data, 0);
        check("clr_hold_blk", blk_cnt, 5);
        // reset mid-block, then reset during HOLD with out_ready high
        feed(3, 3);
        p_reset = 0;
        tick();
        p_reset = 1;
        check("rmb_in_ready", in_if.ready, 1);
        check("rmb_out_valid", out_if.valid, 0);
        check("rmb_blk_cnt", blk_cnt, 0);
        feed(8, 1);
        check("rmb_out_data", out_if.data, 8);
        p_reset = 0; out_if.ready = 1;
        tick();
        p_reset = 1; out_if.ready = 0;
        check("rh_out_valid", out_if.valid, 0);
        check("rh_out_data", out_if.data, 0);
        check("rh_blk_cnt", blk_cnt, 0);
        check("rh_in_ready", in_if.ready, 1);
        // blk_cnt wrap after 256 blocks
        out_if.ready = 1; in_if.valid = 1; in_if.data = 0;
        for (int b = 0; b < 256; b++) begin
            for (int c = 0; c < 9; c++) tick();
            if (b == 254) check("wrap_255", blk_cnt, 255);
        end
        check("wrap_0", blk_cnt, 0);
        in_if.valid = 0; out_if.ready = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
